// File: rtl/uart_rx_pkg.sv
// uart_rx shared types.
// FSM state encodings and default frame width.
package uart_rx_pkg;

  localparam int DEF_DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx bundle: serial/baud side plus
// CPU-side byte output.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 baud_mid;
  logic                 baud_rst;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx,
    input  baud_mid,
    output baud_rst,
    output data,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    output baud_mid,
    input  baud_rst,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_sync_bit.sv
// N-stage synchroniser for one async bit,
// async active-low reset to RST_VAL.
module uart_rx_sync_bit #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  // Shift the async input through N flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ff <= {N{RST_VAL}};
    else      ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a split
// baud generator's mid-bit tick.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_if.master    bus
);

  localparam int CW =
    (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(DATA_BITS - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s;

  uart_rx_sync_bit #(
    .N       (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  // Frame FSM; all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      shreg         <= '0;
      bus.baud_rst  <= 1'b1;
      bus.data      <= '0;
      bus.valid     <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.valid     <= 1'b0;
      bus.frame_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          bus.baud_rst <= 1'b1;
          if (!rx_s) begin
            state        <= S_START;
            bus.baud_rst <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        S_START: begin
          if (bus.baud_mid) begin
            if (rx_s) begin
              state        <= S_IDLE;
              bus.baud_rst <= 1'b1;
              bus.busy     <= 1'b0;
            end else begin
              state <= S_DATA;
              cnt   <= '0;
            end
          end
        end
        S_DATA: begin
          if (bus.baud_mid) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) state <= S_STOP;
          end
        end
        S_STOP: begin
          if (bus.baud_mid) begin
            bus.baud_rst <= 1'b1;
            if (rx_s) begin
              bus.data  <= shreg;
              bus.valid <= 1'b1;
              bus.busy  <= 1'b0;
              state     <= S_IDLE;
            end else begin
              bus.frame_err <= 1'b1;
              state         <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          bus.baud_rst <= 1'b1;
          if (rx_s) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state        <= S_IDLE;
          bus.baud_rst <= 1'b1;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx with a
// behavioural split baud generator.
module tb_uart_rx;

  localparam int P = 16;
  localparam int H = P / 2;

  typedef struct {
    logic       fe;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   gcnt;
  logic [7:0] last_good = 8'h00;
  exp_t q[$];

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(
    .DATA_BITS   (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Baud generator: first tick H cycles after release, then every P.
  always @(posedge clk or negedge rst) begin
    if (!rst)              gcnt <= 0;
    else if (bus.baud_rst) gcnt <= 0;
    else gcnt <= (gcnt == P - 1) ? 0 : gcnt + 1;
  end

  assign bus.baud_mid = !bus.baud_rst && (gcnt == H - 1);

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every strobe.
  always @(negedge clk) begin
    if (rst && (bus.valid || bus.frame_err)) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe",
            {30'd0, bus.valid, bus.frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_kind",
            {30'd0, bus.valid, bus.frame_err},
            e.fe ? 32'd1 : 32'd2);
        chk("strobe_data", {24'd0, bus.data},
            {24'd0, e.data});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b,
                      input logic stop);
    exp_t e;
    e.fe = !stop;
    if (stop) begin
      e.data    = b;
      last_good = b;
    end else begin
      e.data = last_good;
    end
    q.push_back(e);
    bus.rx = 1'b0;
    cyc(P);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      cyc(P);
    end
    bus.rx = stop;
    cyc(P);
  endtask

  task automatic drained(input string name);
    chk(name, q.size(), 32'd0);
    q.delete();
  endtask

  initial begin
    bus.rx = 1'b1;
    cyc(4);
    rst = 1'b1;

    // 1: idle line
    cyc(200);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_baud_rst", {31'd0, bus.baud_rst}, 32'd1);
    chk("idle_valid", {31'd0, bus.valid}, 32'd0);
    chk("idle_fe", {31'd0, bus.frame_err}, 32'd0);
    chk("idle_data", {24'd0, bus.data}, 32'd0);

    // 2: single frame
    send(8'hA5, 1'b1);
    drained("a5_drained");
    chk("a5_busy", {31'd0, bus.busy}, 32'd0);
    chk("a5_data_hold", {24'd0, bus.data}, 32'hA5);
    cyc(2 * P);

    // 3: back-to-back
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    drained("b2b_drained");
    cyc(2 * P);

    // 4: glitch
    bus.rx = 1'b0;
    cyc(P / 4);
    bus.rx = 1'b1;
    cyc(3 * P);
    chk("glitch_busy", {31'd0, bus.busy}, 32'd0);
    chk("glitch_baud_rst", {31'd0, bus.baud_rst}, 32'd1);
    chk("glitch_data", {24'd0, bus.data}, 32'hFF);

    // 5: framing error then break
    send(8'h3C, 1'b0);
    cyc(3 * P);
    drained("fe_drained");
    chk("break_busy", {31'd0, bus.busy}, 32'd1);
    chk("break_baud_rst", {31'd0, bus.baud_rst}, 32'd1);
    chk("break_data", {24'd0, bus.data}, 32'hFF);
    bus.rx = 1'b1;
    cyc(P);
    chk("break_exit_busy", {31'd0, bus.busy}, 32'd0);
    send(8'h5A, 1'b1);
    drained("5a_drained");
    cyc(2 * P);

    // 6: reset during data bit 4 of 0x96
    bus.rx = 1'b0;
    cyc(P);
    for (int i = 0; i < 4; i++) begin
      bus.rx = 8'h96 >> i;
      cyc(P);
    end
    bus.rx = 1'b1;
    cyc(H);
    rst = 1'b0;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_baud_rst", {31'd0, bus.baud_rst}, 32'd1);
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_fe", {31'd0, bus.frame_err}, 32'd0);
    chk("rst_data", {24'd0, bus.data}, 32'd0);
    last_good = 8'h00;
    cyc(3);
    rst = 1'b1;
    cyc(2 * P);
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    send(8'h69, 1'b1);
    drained("69_drained");
    cyc(2 * P);
    chk("final_data", {24'd0, bus.data}, 32'h69);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that sits directly downstream of a BaudGenerator instance configured with SPLIT=1. It consumes that instance's mid-bit tick.
- Controls the generator's RST so that the bit-timing phase locks to each start-bit edge.
- Deserialises 8N1 frames from the RX pin into parallel bytes, with a one-cycle VALID strobe to the CPU-side UART register block.

Parameters:
- DATA_BITS, 8, payload bits per frame, sent LSB first.
- SYNC_STAGES, 2, flip-flop depth of the RX metastability synchroniser (≥2).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- RX  in  1  asynchronous serial line; idles high.
- BAUD_MID  in  1  single-cycle tick from BaudGenerator(SPLIT=1) at each bit centre.
- BAUD_RST  out  1  drives BaudGenerator RST (active-high); 1 holds the generator in phase reset.
- DATA  out  DATA_BITS  last correctly received byte.
- VALID  out  1  one-cycle strobe: DATA updated.
- FRAME_ERR  out  1  one-cycle strobe: stop bit sampled low.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (RST=0, asynchronous): all synchroniser flops 1; state IDLE; BAUD_RST=1; DATA=0; VALID=0; FRAME_ERR=0; BUSY=0; bit counter 0; shift register 0.
- RX passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- BaudGenerator contract: with BAUD_RST low, the first BAUD_MID comes half a bit period after release, then one tick every bit period. BAUD_MID is ignored in IDLE and BREAK.
- State IDLE: BAUD_RST=1. When rx_s=0 is seen, go to START and drive BAUD_RST=0 from the next cycle.
- State START: on BAUD_MID:
  - rx_s=1: false start; go to IDLE and drive BAUD_RST=1.
  - rx_s=0: go to DATA with bit counter=0.
- State DATA: on each BAUD_MID, shift rx_s into the shift register MSB with a right shift (first received bit ends in bit 0) and increment the counter. On the tick where counter=DATA_BITS-1, go to STOP.
- State STOP: on BAUD_MID:
  - rx_s=1: load DATA from the shift register, VALID=1 for exactly the next cycle, go to IDLE.
  - rx_s=0: leave DATA unchanged, FRAME_ERR=1 for exactly the next cycle, go to BREAK.
- State BREAK: BAUD_RST=1. Wait for rx_s=1, then go to IDLE. A line held low never produces repeated frames.
- Latency: VALID/FRAME_ERR are asserted on the cycle after the clock edge that samples the stop-bit BAUD_MID.
- Back-to-back frames: after the stop-bit tick, IDLE is entered immediately. A start edge right after the stop sample is accepted with no idle gap needed.
- VALID and FRAME_ERR are never high in the same cycle. DATA is stable between VALID strobes.
- Reset mid-frame: asynchronous return to the reset values. The partial byte is discarded and no strobe is issued.
- BAUD_MID while BAUD_RST=1 is a generator bug. The receiver ignores it.

Decomposition:
- Shared include uart_defs.vh holds:
  - state encodings S_IDLE, S_START, S_DATA, S_STOP, S_BREAK (3-bit);
  - default DATA_BITS.
  The transmitter uses the same file.
- One natural sub-module, sync_bit: a parameterised N-stage synchroniser with asynchronous active-low reset to a reset value (1 here). It is reused for other asynchronous inputs.
- Bench connects uart_rx to a real BaudGenerator #(.SPLIT(1)) via BAUD_RST/BAUD_MID, with a bit period of P clocks.

Test Plan:
1. Idle line RX=1 for 200 cycles after reset release → BUSY=0, BAUD_RST=1, VALID=0, FRAME_ERR=0, DATA=0x00.
2. Send 0xA5 in 8N1 at period P → exactly one VALID pulse, DATA=0xA5, within one cycle after the stop-bit tick; BUSY back to 0.
3. Back-to-back 0x00 then 0xFF with no idle gap → two VALID pulses, DATA=0x00 then 0xFF; no FRAME_ERR.
4. Glitch: RX low for P/4 then high → false start; return to IDLE, no VALID/FRAME_ERR, BAUD_RST reasserted.
5. Send 0x3C with stop bit forced 0, then hold RX low 3P → single FRAME_ERR pulse, DATA keeps its previous value, state BREAK until RX=1; next frame 0x5A is received correctly.
6. Assert RST low during data bit 4 of 0x96 → all outputs at reset values immediately; after release, frame 0x69 is received with DATA=0x69 and one VALID.
